instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumes the PC from pc_block and fetches instructions from instruction memory
//  over a valid/ready request + valid response interface. Buffers fetched
//  instructions with their PC in a small FIFO for decode.
//  Drives pc_en back to pc_block so the PC only advances when a fetch is accepted.
//  Flushes in-flight and buffered fetches on a control-flow redirect.
// PARAMETERS
//  ADDR_W      11  width of pc / imem address
//  INSTR_W     32  instruction width
//  FIFO_DEPTH  2   fetch queue entries (power of 2, >=2)
// PORTS
//  clk             in   1        clock; all state updates on rising edge
//  rst             in   1        reset, asynchronous, active-high
//  pc              in   ADDR_W   current PC from pc_block
//  redirect        in   1        pc_sel!=00 this cycle (jump/branch taken); flush
//  pc_en           out  1        PC advance/load enable to pc_block
//  imem_req_valid  out  1        fetch request valid
//  imem_req_addr   out  ADDR_W   fetch address (= pc)
//  imem_req_ready  in   1        memory accepts request
//  imem_rsp_valid  in   1        response valid (one per accepted request)
//  imem_rsp_data   in   INSTR_W  fetched instruction
//  instr_valid     out  1        queue head valid to decode
//  instr_data      out  INSTR_W  queue head instruction
//  instr_pc        out  ADDR_W   PC of queue head
//  instr_ready     in   1        decode consumes head
// BEHAVIOUR
//  Clocking/reset: one clock. Reset is asynchronous and active-high.
//  - Reset: state=IDLE, queue empty, pending_pc=0.
//  - Reset outputs: pc_en=0, imem_req_valid=0, imem_req_addr=0, instr_valid=0,
//    instr_data=0, instr_pc=0.
//  - Reset mid-fetch abandons the outstanding request; a later response is
//    ignored because state is IDLE.
//  FSM: IDLE -> REQ (unconditional, 1 cycle after reset release).
//  - REQ: imem_req_valid=1 when (count + 0) < FIFO_DEPTH and !redirect.
//    imem_req_addr=pc (combinational). fire=valid&ready: pending_pc<=pc, go WAIT.
//  - WAIT: at most one request outstanding; imem_req_valid=0.
//    rsp_valid & !redirect: push {pending_pc, rsp_data}, go REQ.
//    redirect & !rsp_valid: go DROP. redirect & rsp_valid: discard response, go REQ.
//  - DROP: next rsp_valid is discarded, go REQ. redirect in DROP: stay DROP.
//  - rsp_valid in IDLE/REQ is a protocol violation: ignore it, state unchanged.
//  pc_en = fire | redirect (combinational).
//  - PC advances exactly once per accepted request.
//  - On redirect, pc_block loads the target; the REQ request is withdrawn that cycle.
//  Request rule: once imem_req_valid=1, addr is held until fire. Redirect is the
//  only allowed withdrawal.
//  Queue: registered FIFO of {pc, instr}, count 0..FIFO_DEPTH, wrap-around pointers.
//  - Pop on instr_valid&instr_ready. Push and pop in the same cycle: count unchanged.
//  - Full: REQ stalls (req_valid=0, pc_en=0) until a pop.
//    Overflow is impossible because a slot is reserved before request issue.
//  - Empty: instr_valid=0; instr_data/instr_pc hold their last values.
//  - redirect: count<=0 and pointers reset next edge, overriding push/pop.
//    instr_valid=0 from the next cycle.
//  Latency: fire at cycle N, rsp at N+k (k>=1), instr_valid at N+k+1.
//  Peak throughput: 1 instr per 2 cycles (k=1, ready always 1).
// TESTING
//  T1 reset: rst=1 with rsp_valid/req_ready toggling -> all outputs 0, no pc_en.
//  T2 stream: pc 0x000,0x004,0x008, ready=1, k=1, instr_ready=1
//     -> instr_pc 0x000/0x004/0x008 with matching data; pc_en pulses once per fire.
//  T3 backpressure: instr_ready=0, FIFO_DEPTH=2 -> two entries buffered, then
//     req_valid=0 and pc_en=0; instr_ready=1 -> fetch resumes at next pc.
//  T4 memory stall: req_ready=0 for 3 cycles, pc=0x040 -> addr held 0x040,
//     pc_en=0 until ready; single push tagged 0x040.
//  T5 redirect in WAIT: fire @0x100, redirect before rsp, rsp data=0xDEAD
//     -> rsp dropped, queue empty, next request uses new pc 0x200.
//  T6 redirect coincident with rsp and pop -> no push; count=0; instr_valid=0 next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one imem request at a time from the incoming PC,
// queues {pc, instr} pairs for decode and flushes everything on a redirect.
module instr_fetch_unit #(
   parameter int ADDR_W     = 11,
   parameter int INSTR_W    = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               redirect,
   output logic               pc_en,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   output logic [1:0]         dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t                      r_state;
   logic [ADDR_W-1:0]           r_pending_pc;
   logic [CNT_W-1:0]            r_count;
   logic [PTR_W-1:0]            r_wr_ptr;
   logic [PTR_W-1:0]            r_rd_ptr;
   logic [ADDR_W+INSTR_W-1:0]   r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]           r_head_pc;
   logic [INSTR_W-1:0]          r_head_data;

   logic                        w_not_full;
   logic                        w_fire;
   logic                        w_push;
   logic                        w_pop;
   logic [CNT_W-1:0]            w_cnt_mid;
   logic [PTR_W-1:0]            w_rd_next;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high.
   // A raised request keeps its address until accepted; only redirect withdraws it.
   assign w_not_full     = (r_count < CNT_W'(FIFO_DEPTH));
   assign imem_req_valid = (r_state == S_REQ) && w_not_full && !redirect;
   assign imem_req_addr  = (r_state == S_IDLE) ? '0 : pc;
   assign w_fire         = imem_req_valid & imem_req_ready;
   assign pc_en          = w_fire | redirect;

   assign w_push    = (r_state == S_WAIT) && imem_rsp_valid && !redirect;
   assign w_pop     = instr_valid & instr_ready;
   assign w_cnt_mid = r_count - CNT_W'(w_pop);
   assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);

   assign instr_valid = (r_count != '0);
   assign instr_data  = r_head_data;
   assign instr_pc    = r_head_pc;
   assign dbg_state   = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pending_pc <= '0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ: begin
               if (w_fire) begin
                  r_pending_pc <= pc;
                  r_state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid)
                  r_state <= S_REQ;
               else if (redirect)
                  r_state <= S_DROP;
            end
            // The abandoned response still has to drain before issuing again.
            S_DROP: begin
               if (imem_rsp_valid)
                  r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_head_pc   <= '0;
         r_head_data <= '0;
      end else if (redirect) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count  <= w_cnt_mid + CNT_W'(w_push);
         r_rd_ptr <= w_rd_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         // Head registers only move onto a live entry, so they hold while empty.
         if (w_push && (w_cnt_mid == '0)) begin
            r_head_pc   <= r_pending_pc;
            r_head_data <= imem_rsp_data;
         end else if (w_pop && (w_cnt_mid != '0)) begin
            {r_head_pc, r_head_data} <= r_mem[w_rd_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {r_pending_pc, imem_rsp_data};
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/decode/redirect traffic against a
// fetch-level model (outstanding request, kill-on-redirect, expected queue).
module tb_instr_fetch_unit;

   localparam int ADDR_W  = 11;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 2;

   logic               clk;
   logic               rst;
   logic [ADDR_W-1:0]  pc;
   logic               redirect;
   logic               pc_en;
   logic               imem_req_valid;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_ready;
   logic [1:0]         dbg_state;

   instr_fetch_unit #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .pc_en(pc_en),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
      .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+INSTR_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // monitor: compares the decode-side head against the expected queue
   logic [ADDR_W-1:0]  last_pc;
   logic [INSTR_W-1:0] last_data;
   always @(negedge clk) begin
      if (rst) begin
         last_pc   = '0;
         last_data = '0;
      end else begin
         check("instr_valid", instr_valid, exp_q.size() != 0);
         if (instr_valid && exp_q.size() != 0) begin
            check("instr_pc", instr_pc, exp_q[0][ADDR_W+INSTR_W-1:INSTR_W]);
            check("instr_data", instr_data, exp_q[0][INSTR_W-1:0]);
            last_pc   = instr_pc;
            last_data = instr_data;
            if (instr_ready) void'(exp_q.pop_front());
         end else if (!instr_valid) begin
            check("hold_pc", instr_pc, last_pc);
            check("hold_data", instr_data, last_data);
         end
      end
   end

   // reference model state
   int                 model_count;
   bit                 started;
   bit                 outstanding;
   bit                 killed;
   int                 countdown;
   logic [ADDR_W-1:0]  out_addr;
   logic [INSTR_W-1:0] out_data;
   logic [ADDR_W-1:0]  target;
   int p_ready, p_iready, p_redir, kmax, p_stray;

   task automatic clear_model();
      exp_q.delete();
      model_count = 0;
      started     = 0;
      outstanding = 0;
      killed      = 0;
      countdown   = 0;
   endtask

   // called at posedge+1; returns at the next posedge+1
   task automatic run_cycle();
      bit rv, fire, pe, pop, push;
      logic [ADDR_W-1:0] addr;
      redirect       = started && ($urandom_range(0, 99) < p_redir);
      target         = ADDR_W'($urandom_range(0, 511) * 4);
      imem_req_ready = ($urandom_range(0, 99) < p_ready);
      instr_ready    = ($urandom_range(0, 99) < p_iready);
      imem_rsp_data  = $urandom;
      imem_rsp_valid = 1'b0;
      if (outstanding) begin
         countdown--;
         if (countdown == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = out_data;
         end
      end else if (!started || $urandom_range(0, 99) < p_stray) begin
         imem_rsp_valid = (started) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rv   = imem_req_valid;
      addr = imem_req_addr;
      pe   = pc_en;
      pop  = instr_valid & instr_ready;
      check("req_valid", rv, started && !outstanding && model_count < DEPTH && !redirect);
      if (rv) check("req_addr", addr, pc);
      fire = rv & imem_req_ready;
      check("pc_en", pe, fire | redirect);
      @(posedge clk);
      push = 0;
      if (imem_rsp_valid && outstanding) begin
         push        = !(killed || redirect);
         outstanding = 0;
      end else if (outstanding && redirect) begin
         killed = 1;
      end
      if (redirect) begin
         exp_q.delete();
         model_count = 0;
      end else begin
         model_count = model_count - int'(pop) + int'(push);
         if (push) exp_q.push_back({out_addr, out_data});
      end
      if (fire) begin
         outstanding = 1;
         killed      = 0;
         countdown   = $urandom_range(1, kmax);
         out_addr    = pc;
         out_data    = $urandom;
      end
      started = 1;
      #1;
      if (pe) pc = redirect ? target : pc + ADDR_W'(4);
   endtask

   task automatic run_phase(input int n, input int rdy, input int irdy, input int redir,
                            input int kmx, input int stray);
      p_ready = rdy; p_iready = irdy; p_redir = redir; kmax = kmx; p_stray = stray;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      redirect = 1'b0;
      pc = '0;
      clear_model();
      for (int i = 0; i < n; i++) begin
         imem_req_ready = 1'($urandom_range(0, 1));
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         instr_ready    = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("rst_pc_en", pc_en, 1'b0);
         check("rst_req_valid", imem_req_valid, 1'b0);
         check("rst_req_addr", imem_req_addr, '0);
         check("rst_instr_valid", instr_valid, 1'b0);
         check("rst_instr_data", instr_data, '0);
         check("rst_instr_pc", instr_pc, '0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // driver / sequence
   initial begin
      rst = 1'b1; pc = '0; redirect = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
      p_ready = 0; p_iready = 0; p_redir = 0; kmax = 1; p_stray = 0;
      clear_model();
      @(posedge clk);
      #1;
      reset_cycles(4);
      run_phase(20, 100, 100, 0, 1, 0);     // streaming, k=1
      run_phase(12, 100, 0, 0, 1, 0);       // decode backpressure fills queue
      run_phase(10, 100, 100, 0, 1, 0);     // resume
      run_phase(40, 25, 100, 0, 3, 0);      // memory stalls, variable latency
      run_phase(200, 70, 70, 20, 3, 0);     // redirect heavy
      run_phase(3, 100, 100, 0, 3, 0);
      reset_cycles(3);                      // mid-run reset abandons outstanding fetch
      run_phase(2000, 60, 60, 6, 3, 5);     // mixed traffic with stray responses
      run_phase(30, 100, 100, 0, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
